afifo_1clk: RTL and testbench

- Single-clock synchronous FIFO with registered read data and full/empty/overflow/underflow status.
- Depth is 2^PWDTH entries of DWDTH bits. The default packs 1 enable bit plus 8 data bits.
- Buffers data between a producer and a consumer running on the same clock.
- Exposes its internal write and read addresses for debug.

---
 rtl/afifo_pkg.sv | 11 +
 rtl/afifo_mem.sv | 47 ++++
 rtl/afifo_1clk.sv | 84 ++++++++
 tb/tb_afifo_1clk.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/afifo_pkg.sv
// Shared defaults and types for the single-clock FIFO.
package afifo_pkg;

  localparam int unsigned DEF_PWDTH = 4;
  localparam int unsigned DEF_DWDTH = 9;
  localparam int unsigned DEF_DEPTH = 1 << DEF_PWDTH;

  // Pointer carries one extra wrap bit to tell full from empty.
  typedef logic [DEF_PWDTH:0] ptr_t;

endpackage

// File: rtl/afifo_mem.sv
// Register-array storage with synchronous write port and registered read port.
module afifo_mem
  import afifo_pkg::*;
#(
  parameter int unsigned AW = DEF_PWDTH,
  parameter int unsigned DW = DEF_DWDTH
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_d, rdata_q;

  // Storage is intentionally left unreset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (re_i) begin
      rdata_d = mem_q[raddr_i];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/afifo_1clk.sv
// Single-clock FIFO: pointer/flag control around afifo_mem.
module afifo_1clk
  import afifo_pkg::*;
#(
  parameter int unsigned PWDTH = DEF_PWDTH,
  parameter int unsigned DWDTH = DEF_DWDTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             winc_i,
  input  logic [DWDTH-1:0] wdata_i,
  input  logic             rinc_i,
  output logic [DWDTH-1:0] rdata_o,
  output logic [PWDTH-1:0] waddr_o,
  output logic [PWDTH-1:0] raddr_o,
  output logic             fifo_full_o,
  output logic             fifo_empty_o,
  output logic             fifo_ovflw_o,
  output logic             fifo_undrflw_o
);

  localparam int unsigned PW = PWDTH + 1;

  logic [PWDTH:0] wptr_d, wptr_q;
  logic [PWDTH:0] rptr_d, rptr_q;
  logic           full_d, full_q;
  logic           empty_d, empty_q;
  logic           ovflw_d, ovflw_q;
  logic           undrflw_d, undrflw_q;
  logic           wr_ok, rd_ok;

  // Acceptance uses pre-edge flags; flags are recomputed from next pointers.
  always_comb begin
    wr_ok     = winc_i & ~full_q;
    rd_ok     = rinc_i & ~empty_q;
    wptr_d    = wptr_q + PW'(wr_ok);
    rptr_d    = rptr_q + PW'(rd_ok);
    ovflw_d   = winc_i & full_q;
    undrflw_d = rinc_i & empty_q;
    empty_d   = (wptr_d == rptr_d);
    full_d    = (wptr_d[PWDTH] != rptr_d[PWDTH]) &&
                (wptr_d[PWDTH-1:0] == rptr_d[PWDTH-1:0]);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      ovflw_q   <= 1'b0;
      undrflw_q <= 1'b0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      full_q    <= full_d;
      empty_q   <= empty_d;
      ovflw_q   <= ovflw_d;
      undrflw_q <= undrflw_d;
    end
  end

  afifo_mem #(
    .AW (PWDTH),
    .DW (DWDTH)
  ) u_mem (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .we_i    (wr_ok & ~rst_i),
    .waddr_i (wptr_q[PWDTH-1:0]),
    .wdata_i (wdata_i),
    .re_i    (rd_ok),
    .raddr_i (rptr_q[PWDTH-1:0]),
    .rdata_o (rdata_o)
  );

  assign waddr_o        = wptr_q[PWDTH-1:0];
  assign raddr_o        = rptr_q[PWDTH-1:0];
  assign fifo_full_o    = full_q;
  assign fifo_empty_o   = empty_q;
  assign fifo_ovflw_o   = ovflw_q;
  assign fifo_undrflw_o = undrflw_q;

endmodule

// File: tb/tb_afifo_1clk.sv
// Scoreboard bench for afifo_1clk: queue-based reference model, directed then random traffic.
module tb_afifo_1clk;

  logic       clk = 1'b0;
  logic       rst_i = 1'b1;
  logic       winc_i = 1'b0;
  logic [8:0] wdata_i = '0;
  logic       rinc_i = 1'b0;
  logic [8:0] rdata_o;
  logic [3:0] waddr_o, raddr_o;
  logic       fifo_full_o, fifo_empty_o, fifo_ovflw_o, fifo_undrflw_o;

  always #5 clk = ~clk;

  afifo_1clk dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .winc_i         (winc_i),
    .wdata_i        (wdata_i),
    .rinc_i         (rinc_i),
    .rdata_o        (rdata_o),
    .waddr_o        (waddr_o),
    .raddr_o        (raddr_o),
    .fifo_full_o    (fifo_full_o),
    .fifo_empty_o   (fifo_empty_o),
    .fifo_ovflw_o   (fifo_ovflw_o),
    .fifo_undrflw_o (fifo_undrflw_o)
  );

  typedef struct {
    logic       full;
    logic       empty;
    logic       ovf;
    logic       udf;
    logic [8:0] rd;
    logic [3:0] wa;
    logic [3:0] ra;
  } exp_t;

  exp_t expq[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  // Reference model state: contents as a plain queue, addresses as counters mod 16.
  logic [8:0] m_q[$];
  int         m_wa = 0;
  int         m_ra = 0;
  logic [8:0] m_rd = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Drive one cycle of inputs, advance the model, queue the post-edge expectation.
  task automatic step(input logic rst, input logic w, input logic [8:0] d, input logic r);
    exp_t e;
    bit   was_full, was_empty;
    rst_i   = rst;
    winc_i  = w;
    wdata_i = d;
    rinc_i  = r;
    was_full  = (m_q.size() == 16);
    was_empty = (m_q.size() == 0);
    if (rst) begin
      m_q.delete();
      m_wa = 0;
      m_ra = 0;
      m_rd = '0;
      e.ovf = 1'b0;
      e.udf = 1'b0;
    end else begin
      e.ovf = w && was_full;
      e.udf = r && was_empty;
      if (r && !was_empty) begin
        m_rd = m_q.pop_front();
        m_ra = (m_ra + 1) % 16;
      end
      if (w && !was_full) begin
        m_q.push_back(d);
        m_wa = (m_wa + 1) % 16;
      end
    end
    e.full  = (m_q.size() == 16);
    e.empty = (m_q.size() == 0);
    e.rd    = m_rd;
    e.wa    = 4'(m_wa);
    e.ra    = 4'(m_ra);
    @(posedge clk);
    expq.push_back(e);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 9'h0, 1'b0);
  endtask

  // Monitor: compare every cycle's outputs at the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      chk("full",    32'(fifo_full_o),    32'(e.full));
      chk("empty",   32'(fifo_empty_o),   32'(e.empty));
      chk("ovflw",   32'(fifo_ovflw_o),   32'(e.ovf));
      chk("undrflw", 32'(fifo_undrflw_o), 32'(e.udf));
      chk("rdata",   32'(rdata_o),        32'(e.rd));
      chk("waddr",   32'(waddr_o),        32'(e.wa));
      chk("raddr",   32'(raddr_o),        32'(e.ra));
    end
  end

  initial begin
    step(1'b1, 1'b0, 9'h0, 1'b0);
    step(1'b1, 1'b0, 9'h0, 1'b0);
    idle(1);

    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 9'(9'h100 + i), 1'b0);
      idle(1);
    end
    step(1'b0, 1'b1, 9'h1FF, 1'b0);
    idle(2);

    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b0, 9'h0, 1'b1);
      idle(1);
    end
    step(1'b0, 1'b0, 9'h0, 1'b1);
    idle(2);

    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 9'(9'h020 + i), 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 9'(9'h030 + i), 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 9'h0, 1'b1);
    idle(1);

    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 9'(9'h040 + i), 1'b0);
    step(1'b0, 1'b1, 9'h0EE, 1'b1);
    idle(1);
    for (int i = 0; i < 15; i++) step(1'b0, 1'b0, 9'h0, 1'b1);
    idle(1);

    step(1'b0, 1'b1, 9'h055, 1'b1);
    idle(1);
    step(1'b0, 1'b0, 9'h0, 1'b1);
    idle(1);

    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 9'(9'h060 + i), 1'b0);
    step(1'b1, 1'b0, 9'h0, 1'b0);
    idle(1);
    step(1'b0, 1'b1, 9'h0AA, 1'b0);
    step(1'b0, 1'b0, 9'h0, 1'b1);
    idle(2);

    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 99) == 0),
           ($urandom_range(0, 99) < 55),
           9'($urandom),
           ($urandom_range(0, 99) < 50));
    end
    idle(2);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(expq.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
